// File: rtl/fat32_write_addr_gen.sv
// FAT32 write-path sector address generator.
// Computes the data-region base (reserved + NUM_FAT * fat_length) by repeated
// addition, then walks a contiguous cluster run one sector at a time and
// reports the FAT entry location each time a cluster is fully consumed.
module fat32_write_addr_gen #(
    parameter int unsigned NUM_FAT    = 2,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned SPC_LOG2_W = 3
) (
    input  logic                            clk,
    input  logic                            sys_rst_n,
    input  logic                            cfg_load,
    input  logic [15:0]                     reserved_sectors,
    input  logic [ADDR_W-1:0]               fat_length,
    input  logic [SPC_LOG2_W-1:0]           spc_log2,
    input  logic [ADDR_W-1:0]               max_cluster,
    output logic                            cfg_done,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               start_cluster,
    output logic                            addr_valid,
    input  logic                            addr_next,
    output logic [ADDR_W-1:0]               sector_addr,
    output logic [ADDR_W-1:0]               cur_cluster,
    output logic [(2**SPC_LOG2_W)-2:0]      sec_in_clus,
    output logic [ADDR_W-1:0]               data_base,
    output logic                            clus_done,
    output logic [ADDR_W-1:0]               fat_sector,
    output logic [8:0]                      fat_offset,
    output logic                            err
);

    localparam int unsigned SIC_W = (2**SPC_LOG2_W) - 1;
    localparam int unsigned CNT_W = (NUM_FAT + 1 > 2) ? $clog2(NUM_FAT + 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CALC      = 3'd1,
        READY     = 3'd2,
        ACTIVE    = 3'd3,
        NEXT_CLUS = 3'd4
    } state_t;

    state_t                  state_q;

    // Captured configuration
    logic [15:0]             reserved_q;
    logic [ADDR_W-1:0]       fat_length_q;
    logic [SPC_LOG2_W-1:0]   spc_log2_q;
    logic [ADDR_W-1:0]       max_cluster_q;

    // Base accumulation
    logic [ADDR_W-1:0]       acc_q;
    logic [CNT_W-1:0]        count_q;

    // Registered outputs
    logic [ADDR_W-1:0]       data_base_q;
    logic                    cfg_done_q;
    logic                    addr_valid_q;
    logic [ADDR_W-1:0]       sector_addr_q;
    logic [ADDR_W-1:0]       cur_cluster_q;
    logic [SIC_W-1:0]        sec_in_clus_q;
    logic                    clus_done_q;
    logic [ADDR_W-1:0]       fat_sector_q;
    logic [8:0]              fat_offset_q;
    logic                    err_q;

    // Values loaded into the registers on start / cluster completion
    logic                    start_ok_d;
    logic [ADDR_W-1:0]       start_addr_d;
    logic [SIC_W-1:0]        last_idx_d;
    logic                    last_sec_d;
    logic [ADDR_W-1:0]       fat_sector_d;
    logic [8:0]              fat_offset_d;

    // Start-address, range and cluster-end decode from captured config and current position
    always_comb begin
        start_ok_d   = (start_cluster >= ADDR_W'(2)) && (start_cluster <= max_cluster_q);
        start_addr_d = data_base_q + ((start_cluster - ADDR_W'(2)) << spc_log2_q);
        last_idx_d   = ~({SIC_W{1'b1}} << spc_log2_q);
        last_sec_d   = (sec_in_clus_q == last_idx_d);
        fat_sector_d = ADDR_W'(reserved_q) + (cur_cluster_q >> 7);
        fat_offset_d = {cur_cluster_q[6:0], 2'b00};
    end

    // Control FSM: config capture, base accumulation, sector walk and FAT entry reporting
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= IDLE;
            reserved_q    <= '0;
            fat_length_q  <= '0;
            spc_log2_q    <= '0;
            max_cluster_q <= '0;
            acc_q         <= '0;
            count_q       <= '0;
            data_base_q   <= '0;
            cfg_done_q    <= 1'b0;
            addr_valid_q  <= 1'b0;
            sector_addr_q <= '0;
            cur_cluster_q <= '0;
            sec_in_clus_q <= '0;
            clus_done_q   <= 1'b0;
            fat_sector_q  <= '0;
            fat_offset_q  <= '0;
            err_q         <= 1'b0;
        end else begin
            clus_done_q <= 1'b0;
            if (cfg_load) begin
                reserved_q    <= reserved_sectors;
                fat_length_q  <= fat_length;
                spc_log2_q    <= spc_log2;
                max_cluster_q <= max_cluster;
                acc_q         <= ADDR_W'(reserved_sectors);
                count_q       <= '0;
                addr_valid_q  <= 1'b0;
                cfg_done_q    <= 1'b0;
                err_q         <= 1'b0;
                state_q       <= CALC;
            end else if (start && (state_q inside {READY, ACTIVE, NEXT_CLUS})) begin
                // start outranks addr_next and the pending NEXT_CLUS advance
                if (start_ok_d) begin
                    err_q         <= 1'b0;
                    cur_cluster_q <= start_cluster;
                    sec_in_clus_q <= '0;
                    sector_addr_q <= start_addr_d;
                    addr_valid_q  <= 1'b1;
                    state_q       <= ACTIVE;
                end else begin
                    err_q         <= 1'b1;
                    addr_valid_q  <= 1'b0;
                    state_q       <= READY;
                end
            end else begin
                case (state_q)
                    CALC: begin
                        if (count_q == CNT_W'(NUM_FAT)) begin
                            data_base_q <= acc_q;
                            cfg_done_q  <= 1'b1;
                            state_q     <= READY;
                        end else begin
                            acc_q   <= acc_q + fat_length_q;
                            count_q <= count_q + CNT_W'(1);
                        end
                    end
                    ACTIVE: begin
                        if (addr_next && addr_valid_q) begin
                            if (!last_sec_d) begin
                                sec_in_clus_q <= sec_in_clus_q + SIC_W'(1);
                                sector_addr_q <= sector_addr_q + ADDR_W'(1);
                            end else begin
                                clus_done_q  <= 1'b1;
                                fat_sector_q <= fat_sector_d;
                                fat_offset_q <= fat_offset_d;
                                addr_valid_q <= 1'b0;
                                state_q      <= NEXT_CLUS;
                            end
                        end
                    end
                    NEXT_CLUS: begin
                        // cur_cluster + 1 > max_cluster, written without the +1 so it cannot wrap
                        if (cur_cluster_q >= max_cluster_q) begin
                            err_q        <= 1'b1;
                            addr_valid_q <= 1'b0;
                            state_q      <= READY;
                        end else begin
                            cur_cluster_q <= cur_cluster_q + ADDR_W'(1);
                            sec_in_clus_q <= '0;
                            sector_addr_q <= sector_addr_q + ADDR_W'(1);
                            addr_valid_q  <= 1'b1;
                            state_q       <= ACTIVE;
                        end
                    end
                    IDLE, READY: begin
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign cfg_done    = cfg_done_q;
    assign addr_valid  = addr_valid_q;
    assign sector_addr = sector_addr_q;
    assign cur_cluster = cur_cluster_q;
    assign sec_in_clus = sec_in_clus_q;
    assign data_base   = data_base_q;
    assign clus_done   = clus_done_q;
    assign fat_sector  = fat_sector_q;
    assign fat_offset  = fat_offset_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fat32_write_addr_gen.sv
// Self-checking bench for fat32_write_addr_gen: directed stimulus, a
// behavioural reference model compared every cycle, and literal spot values.
module tb_fat32_write_addr_gen;

    localparam int NUM_FAT    = 2;
    localparam int ADDR_W     = 32;
    localparam int SPC_LOG2_W = 3;

    logic        clk = 1'b0;
    logic        sys_rst_n = 1'b1;
    logic        cfg_load = 1'b0;
    logic [15:0] reserved_sectors = '0;
    logic [31:0] fat_length = '0;
    logic [2:0]  spc_log2 = '0;
    logic [31:0] max_cluster = '0;
    logic        cfg_done;
    logic        start = 1'b0;
    logic [31:0] start_cluster = '0;
    logic        addr_valid;
    logic        addr_next = 1'b0;
    logic [31:0] sector_addr;
    logic [31:0] cur_cluster;
    logic [6:0]  sec_in_clus;
    logic [31:0] data_base;
    logic        clus_done;
    logic [31:0] fat_sector;
    logic [8:0]  fat_offset;
    logic        err;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fat32_write_addr_gen #(
        .NUM_FAT    (NUM_FAT),
        .ADDR_W     (ADDR_W),
        .SPC_LOG2_W (SPC_LOG2_W)
    ) dut (
        .clk              (clk),
        .sys_rst_n        (sys_rst_n),
        .cfg_load         (cfg_load),
        .reserved_sectors (reserved_sectors),
        .fat_length       (fat_length),
        .spc_log2         (spc_log2),
        .max_cluster      (max_cluster),
        .cfg_done         (cfg_done),
        .start            (start),
        .start_cluster    (start_cluster),
        .addr_valid       (addr_valid),
        .addr_next        (addr_next),
        .sector_addr      (sector_addr),
        .cur_cluster      (cur_cluster),
        .sec_in_clus      (sec_in_clus),
        .data_base        (data_base),
        .clus_done        (clus_done),
        .fat_sector       (fat_sector),
        .fat_offset       (fat_offset),
        .err              (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] m_res = '0;
    logic [31:0] m_fl = '0, m_max = '0, m_base = '0, m_cur = '0, m_fat_sector = '0;
    logic [8:0]  m_fat_offset = '0;
    int          m_spc = 0, m_sic = 0, m_calc_left = 0;
    bit          m_cfg_done = 0, m_valid = 0, m_err = 0, m_gap = 0, m_clus_done = 0;
    logic [31:0] exp_addr;

    always @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_res = '0; m_fl = '0; m_max = '0; m_base = '0; m_cur = '0;
            m_fat_sector = '0; m_fat_offset = '0; m_spc = 0; m_sic = 0;
            m_calc_left = 0; m_cfg_done = 0; m_valid = 0; m_err = 0;
            m_gap = 0; m_clus_done = 0;
        end else begin
            m_clus_done = 0;
            if (cfg_load) begin
                m_res = reserved_sectors; m_fl = fat_length;
                m_spc = int'(spc_log2); m_max = max_cluster;
                m_calc_left = NUM_FAT + 1;
                m_cfg_done = 0; m_valid = 0; m_err = 0; m_gap = 0;
            end else if (m_calc_left > 0) begin
                m_calc_left--;
                if (m_calc_left == 0) begin
                    m_base = 32'(m_res) + 32'(NUM_FAT) * m_fl;
                    m_cfg_done = 1;
                end
            end else if (m_cfg_done && start) begin
                m_gap = 0;
                if (start_cluster < 2 || start_cluster > m_max) begin
                    m_err = 1; m_valid = 0;
                end else begin
                    m_err = 0; m_cur = start_cluster; m_sic = 0; m_valid = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
                if (longint'(m_cur) + 1 > longint'(m_max)) begin
                    m_err = 1;
                end else begin
                    m_cur = m_cur + 1; m_sic = 0; m_valid = 1;
                end
            end else if (m_valid && addr_next) begin
                if (m_sic + 1 < (1 << m_spc)) begin
                    m_sic++;
                end else begin
                    m_clus_done  = 1;
                    m_fat_sector = 32'(m_res) + m_cur / 128;
                    m_fat_offset = 9'((m_cur % 128) * 4);
                    m_valid = 0;
                    m_gap = 1;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("addr_valid", 32'(addr_valid), 32'(m_valid));
            check("cfg_done",   32'(cfg_done),   32'(m_cfg_done));
            check("err",        32'(err),        32'(m_err));
            check("clus_done",  32'(clus_done),  32'(m_clus_done));
            check("data_base",  data_base,       m_base);
            check("fat_sector", fat_sector,      m_fat_sector);
            check("fat_offset", 32'(fat_offset), 32'(m_fat_offset));
            if (m_valid) begin
                exp_addr = m_base + ((m_cur - 32'd2) << m_spc) + 32'(m_sic);
                check("sector_addr", sector_addr,      exp_addr);
                check("cur_cluster", cur_cluster,      m_cur);
                check("sec_in_clus", 32'(sec_in_clus), 32'(m_sic));
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_cfg(input logic [15:0] r, input logic [31:0] fl,
                          input logic [2:0] s, input logic [31:0] mx);
        reserved_sectors = r; fat_length = fl; spc_log2 = s; max_cluster = mx;
        cfg_load = 1'b1;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic wait_cfg_done(output int n);
        n = 0;
        while (!cfg_done && n < 16) begin
            step();
            n++;
        end
        if (!cfg_done) check("cfg_done_timeout", 32'(cfg_done), 32'd1);
    endtask

    task automatic do_start(input logic [31:0] c);
        start_cluster = c;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic consume(input int n);
        for (int i = 0; i < n; i++) begin
            int w = 0;
            while (!addr_valid && w < 20) begin
                step();
                w++;
            end
            if (!addr_valid) check("addr_valid_timeout", 32'(addr_valid), 32'd1);
            addr_next = 1'b1;
            step();
            addr_next = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        #2 sys_rst_n = 1'b0;
        #10;
        @(negedge clk);
        sys_rst_n = 1'b1;
        chk_en = 1'b1;
        step();

        // Reset state
        check("rst_cfg_done",   32'(cfg_done),   32'd0);
        check("rst_addr_valid", 32'(addr_valid), 32'd0);
        check("rst_data_base",  data_base,       32'd0);
        check("rst_err",        32'(err),        32'd0);

        // Base computation: 32 + 2*1000
        do_cfg(16'd32, 32'd1000, 3'd3, 32'd1000);
        wait_cfg_done(n);
        check("calc_latency", 32'(n),    32'd3);
        check("base_2032",    data_base, 32'd2032);
        check("base_err",     32'(err),  32'd0);

        // Start address and in-cluster advance
        do_start(32'd5);
        check("start5_addr",  sector_addr,      32'd2056);
        check("start5_valid", 32'(addr_valid),  32'd1);
        consume(3);
        check("adv3_addr",    sector_addr,      32'd2059);
        check("adv3_sic",     32'(sec_in_clus), 32'd3);

        // Cluster boundary from cluster 2
        do_start(32'd2);
        consume(7);
        check("c2_last_addr", sector_addr,     32'd2039);
        consume(1);
        check("c2_clus_done", 32'(clus_done),  32'd1);
        check("c2_fat_sec",   fat_sector,      32'd32);
        check("c2_fat_off",   32'(fat_offset), 32'd8);
        check("c2_gap_valid", 32'(addr_valid), 32'd0);
        step();
        check("c3_valid",     32'(addr_valid), 32'd1);
        check("c3_addr",      sector_addr,     32'd2040);
        check("c3_cluster",   cur_cluster,     32'd3);
        check("c3_done_low",  32'(clus_done),  32'd0);

        // FAT offset wrap at cluster 127 -> 128
        do_start(32'd127);
        check("c127_addr",    sector_addr,     32'd3032);
        consume(8);
        check("c127_fat_sec", fat_sector,      32'd32);
        check("c127_fat_off", 32'(fat_offset), 32'd508);
        step();
        check("c128_cluster", cur_cluster,     32'd128);
        check("c128_addr",    sector_addr,     32'd3040);
        consume(8);
        check("c128_fat_sec", fat_sector,      32'd33);
        check("c128_fat_off", 32'(fat_offset), 32'd0);

        // Range error on start (issued during the NEXT_CLUS cycle), then clear
        do_start(32'd1);
        check("s1_err",       32'(err),        32'd1);
        check("s1_valid",     32'(addr_valid), 32'd0);
        do_start(32'd10);
        check("s10_err",      32'(err),        32'd0);
        check("s10_addr",     sector_addr,     32'd2096);

        // Run off the end of the volume
        do_cfg(16'd32, 32'd1000, 3'd3, 32'd3);
        wait_cfg_done(n);
        do_start(32'd4);
        check("s4_err",       32'(err),        32'd1);
        do_start(32'd3);
        check("s3_err_clr",   32'(err),        32'd0);
        check("s3_addr",      sector_addr,     32'd2040);
        consume(8);
        check("end_clus_done", 32'(clus_done), 32'd1);
        check("end_fat_off",  32'(fat_offset), 32'd12);
        step();
        check("end_err",      32'(err),        32'd1);
        check("end_valid",    32'(addr_valid), 32'd0);
        check("end_cfg_done", 32'(cfg_done),   32'd1);
        do_start(32'd2);
        check("end_err_clr",  32'(err),        32'd0);
        check("end_restart",  sector_addr,     32'd2032);

        // cfg_load aborts an active run; start during CALC is ignored
        do_cfg(16'd100, 32'd50, 3'd2, 32'd5000);
        check("abort_valid",  32'(addr_valid), 32'd0);
        check("abort_cfg",    32'(cfg_done),   32'd0);
        do_start(32'd3);
        check("calc_start_ign", 32'(addr_valid), 32'd0);
        wait_cfg_done(n);
        check("base_200",     data_base,       32'd200);

        // start + addr_next together: start wins
        do_start(32'd7);
        check("s7_addr",      sector_addr,     32'd220);
        consume(2);
        check("s7_adv2",      sector_addr,     32'd222);
        start_cluster = 32'd9;
        start = 1'b1;
        addr_next = 1'b1;
        step();
        start = 1'b0;
        addr_next = 1'b0;
        check("prio_cluster", cur_cluster,      32'd9);
        check("prio_sic",     32'(sec_in_clus), 32'd0);
        check("prio_addr",    sector_addr,      32'd228);
        consume(4);
        check("c9_fat_sec",   fat_sector,      32'd100);
        check("c9_fat_off",   32'(fat_offset), 32'd36);
        do_start(32'd20);
        check("gap_seek_cl",  cur_cluster,     32'd20);
        check("gap_seek_addr", sector_addr,    32'd272);

        // Asynchronous reset mid-run
        consume(1);
        @(posedge clk);
        #3;
        sys_rst_n = 1'b0;
        #1;
        check("arst_valid",   32'(addr_valid),  32'd0);
        check("arst_addr",    sector_addr,      32'd0);
        check("arst_cluster", cur_cluster,      32'd0);
        check("arst_sic",     32'(sec_in_clus), 32'd0);
        check("arst_base",    data_base,        32'd0);
        check("arst_cfg",     32'(cfg_done),    32'd0);
        check("arst_fat_sec", fat_sector,       32'd0);
        check("arst_fat_off", 32'(fat_offset),  32'd0);
        check("arst_err",     32'(err),         32'd0);
        step();
        step();
        @(negedge clk);
        sys_rst_n = 1'b1;
        step();
        do_start(32'd5);
        check("idle_start_ign", 32'(addr_valid), 32'd0);

        // One-sector clusters
        do_cfg(16'd1, 32'd3, 3'd0, 32'd10);
        wait_cfg_done(n);
        check("base_7",       data_base,       32'd7);
        do_start(32'd2);
        check("spc0_addr",    sector_addr,     32'd7);
        consume(1);
        check("spc0_done",    32'(clus_done),  32'd1);
        check("spc0_fat_sec", fat_sector,      32'd1);
        check("spc0_fat_off", 32'(fat_offset), 32'd8);
        step();
        check("spc0_next",    sector_addr,     32'd8);
        check("spc0_cluster", cur_cluster,     32'd3);
        step();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fat32_write_addr_gen.md
Name: fat32_write_addr_gen

Overview:
Sequential sector-address generator for the FAT32 file-write path.
- After a config load it computes the data-region base: reserved sectors + FAT length × FAT count, by iterative accumulation, so no multiplier is needed.
- It then walks a contiguous cluster run sector by sector, emitting the absolute SD block address for each sector.
- At every cluster boundary it reports the FAT entry location (sector and byte offset) so the FAT-update logic can write that entry.

Parameters:
NUM_FAT, 2, number of FAT copies; CALC accumulates fat_length this many times.
ADDR_W, 32, width of sector addresses and cluster numbers.
SPC_LOG2_W, 3, width of sectors-per-cluster log2 input; the maximum cluster size is 2^(2^SPC_LOG2_W - 1) sectors.

Ports:
clk  in  1  system clock; all logic is rising-edge.
sys_rst_n  in  1  reset, asynchronous, active-low.
cfg_load  in  1  1-cycle pulse; captures the config inputs and starts CALC.
reserved_sectors  in  16  BPB reserved sector count.
fat_length  in  ADDR_W  sectors per FAT.
spc_log2  in  SPC_LOG2_W  log2 of sectors per cluster.
max_cluster  in  ADDR_W  highest valid cluster number, inclusive.
cfg_done  out  1  high once the base is computed and the block is idle or active.
start  in  1  1-cycle pulse; begins or seeks to start_cluster, sector 0.
start_cluster  in  ADDR_W  first cluster of the run.
addr_valid  out  1  sector_addr is valid for the consumer.
addr_next  in  1  1-cycle pulse; the consumer has written the current sector.
sector_addr  out  ADDR_W  absolute sector address.
cur_cluster  out  ADDR_W  current cluster number.
sec_in_clus  out  2^SPC_LOG2_W-1  sector index within the cluster.
data_base  out  ADDR_W  computed data-region start, the sector of cluster 2.
clus_done  out  1  1-cycle pulse when a cluster is fully consumed.
fat_sector  out  ADDR_W  FAT1 sector holding the finished cluster's entry; valid with clus_done.
fat_offset  out  9  byte offset of that entry; valid with clus_done.
err  out  1  sticky range error; cleared by cfg_load or a valid start.

Behaviour:
- Reset: all outputs 0; state IDLE; captured config 0.
- States: IDLE, CALC, READY, ACTIVE, NEXT_CLUS.
- IDLE: waits for cfg_load. start and addr_next are ignored.
- cfg_load, accepted in any state:
  - latches reserved_sectors, fat_length, spc_log2 and max_cluster;
  - sets acc = reserved_sectors and count = 0; clears addr_valid, cfg_done and err;
  - goes to CALC.
- CALC: each cycle acc += fat_length (ADDR_W-bit add, wraps mod 2^ADDR_W). After NUM_FAT cycles: data_base = acc, cfg_done = 1, go to READY.
- Latency from cfg_load to cfg_done is NUM_FAT+1 cycles.
- start, accepted in READY or ACTIVE, or in NEXT_CLUS where it takes priority:
  - If start_cluster < 2 or start_cluster > max_cluster: err = 1, addr_valid = 0, go to READY.
  - Otherwise cur_cluster = start_cluster, sec_in_clus = 0, go to ACTIVE.
  - The next cycle gives sector_addr = data_base + ((start_cluster - 2) << spc_log2) and addr_valid = 1.
- ACTIVE, on addr_next while addr_valid:
  - If sec_in_clus < 2^spc_log2 - 1: sec_in_clus++ and sector_addr++ in the next cycle; addr_valid stays high.
  - Else, the last sector was consumed:
    - clus_done pulses for 1 cycle;
    - fat_sector = reserved_sectors + (cur_cluster >> 7);
    - fat_offset = {cur_cluster[6:0], 2'b00};
    - addr_valid drops; go to NEXT_CLUS.
- NEXT_CLUS, 1 cycle:
  - If cur_cluster + 1 > max_cluster: err = 1, go to READY with addr_valid = 0.
  - Otherwise cur_cluster++, sec_in_clus = 0, sector_addr++ (contiguous data region), addr_valid = 1, back to ACTIVE.
  - Boundary latency: addr_valid is low for exactly 1 cycle.
- addr_next while addr_valid = 0 is ignored.
- addr_next and start in the same cycle: start wins; the addr_next is dropped.
- fat_sector and fat_offset hold their value until the next clus_done.
- cfg_done stays 1 in READY, ACTIVE and NEXT_CLUS.
- An asynchronous reset mid-run returns everything to the reset values immediately.

Test Plan:
- Base computation: reserved=32, fat_length=1000, NUM_FAT=2, cfg_load → cfg_done rises after 3 cycles, data_base=2032, err=0.
- Start address: spc_log2=3, start_cluster=5 → next cycle sector_addr=2056, addr_valid=1; 3× addr_next → sector_addr=2059, sec_in_clus=3.
- Cluster boundary: start_cluster=2, 8× addr_next with addr_valid checked →
  - 8th pulse gives clus_done=1, fat_sector=32, fat_offset=8;
  - addr_valid is low 1 cycle, then sector_addr=2040, cur_cluster=3.
- FAT offset wrap: start_cluster=127, consume 8 sectors → fat_sector=32, fat_offset=508, then cur_cluster=128; consume 8 more → fat_sector=33, fat_offset=0.
- Range errors:
  - start_cluster=1 → err=1, addr_valid=0;
  - max_cluster=3, start_cluster=3, consume 8 sectors → clus_done pulses, then err=1 and state READY;
  - a subsequent valid start clears err.
- Abort and priority:
  - cfg_load while ACTIVE → addr_valid=0, CALC reruns;
  - start and addr_next in the same cycle → seek to the new cluster at sector 0;
  - sys_rst_n low mid-run → all outputs 0 asynchronously.
